// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - operand sequencer driving skewed, zero-padded A/B streams into an NxN systolic MAC array
// Optional stall support is compiled in with MAC_FEEDER_STALL_EN.
module mac_feeder #(
  parameter int N     = 4,
  parameter int K_MAX = 16
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       ld_valid,
  input  logic                       ld_sel,
  input  logic [$clog2(N)-1:0]       ld_idx,
  input  logic [$clog2(K_MAX)-1:0]   ld_k,
  input  logic [3:0]                 ld_data,
  output logic                       ld_ready,
  input  logic                       start,
  input  logic [$clog2(K_MAX):0]     k_len,
  input  logic                       stall,
  output logic [4*N-1:0]             a_edge,
  output logic [4*N-1:0]             b_edge,
  output logic                       mac_en,
  output logic                       mac_upd,
  output logic                       mac_clr,
  output logic                       busy,
  output logic                       run_done,
  output logic                       start_err
);

  localparam int KW = $clog2(K_MAX);
  localparam int CW = $clog2(K_MAX + 2*N);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t          state;
  logic [3:0]      a_buf [N][K_MAX];
  logic [3:0]      b_buf [N][K_MAX];
  logic [KW:0]     k_reg;
  logic [CW-1:0]   c;
  logic [CW-1:0]   c_nxt;
  logic [CW-1:0]   last_c;
  logic [4*N-1:0]  a_nxt;
  logic [4*N-1:0]  b_nxt;
  logic            start_ok;

`ifndef MAC_FEEDER_STALL_EN
  logic unused_stall;
  assign unused_stall = stall;
`endif

  assign start_ok = (k_len != '0) && (k_len <= (KW+1)'(K_MAX));
  assign c_nxt    = (state == RUN) ? c + 1'b1 : '0;
  assign last_c   = CW'(k_reg) + CW'(2*N - 3);

  // Edge lane i carries element k = c - i; outside 0..K-1 it is padded with zero.
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    for (int i = 0; i < N; i++) begin
      logic [CW-1:0] d;
      d = c_nxt - CW'(i);
      if ((c_nxt >= CW'(i)) && (d < CW'(k_reg))) begin
        a_nxt[4*i +: 4] = a_buf[i][d[KW-1:0]];
        b_nxt[4*i +: 4] = b_buf[i][d[KW-1:0]];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < K_MAX; k++) begin
          a_buf[i][k] <= '0;
          b_buf[i][k] <= '0;
        end
      end
    end else if (ld_valid && (state == IDLE)) begin
      if (ld_sel) b_buf[ld_idx][ld_k] <= ld_data;
      else        a_buf[ld_idx][ld_k] <= ld_data;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      k_reg     <= '0;
      c         <= '0;
      a_edge    <= '0;
      b_edge    <= '0;
      mac_en    <= 1'b0;
      mac_upd   <= 1'b0;
      mac_clr   <= 1'b0;
      busy      <= 1'b0;
      run_done  <= 1'b0;
      start_err <= 1'b0;
      ld_ready  <= 1'b1;
    end else begin
      start_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              k_reg    <= k_len;
              state    <= CLEAR;
              busy     <= 1'b1;
              ld_ready <= 1'b0;
              mac_clr  <= 1'b1;
              mac_en   <= 1'b1;
              mac_upd  <= 1'b1;
            end else begin
              start_err <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state   <= RUN;
          c       <= c_nxt;
          a_edge  <= a_nxt;
          b_edge  <= b_nxt;
          mac_clr <= 1'b0;
        end
        RUN: begin
`ifdef MAC_FEEDER_STALL_EN
          // Gating enable freezes the array while the held edges wait.
          if (stall) begin
            mac_en  <= 1'b0;
            mac_upd <= 1'b0;
          end else
`endif
          if (c == last_c) begin
            state    <= DONE;
            run_done <= 1'b1;
            a_edge   <= '0;
            b_edge   <= '0;
            mac_en   <= 1'b0;
            mac_upd  <= 1'b0;
          end else begin
            c       <= c_nxt;
            a_edge  <= a_nxt;
            b_edge  <= b_nxt;
            mac_en  <= 1'b1;
            mac_upd <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          run_done <= 1'b0;
          busy     <= 1'b0;
          ld_ready <= 1'b1;
          c        <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - self-checking bench for mac_feeder with a behavioural systolic array model
module tb_mac_feeder;
  localparam int N = 4;
  localparam int K_MAX = 16;

  logic CLK = 1'b0;
  logic RSTN;
  logic ld_valid, ld_sel, start, stall;
  logic [1:0] ld_idx;
  logic [3:0] ld_k, ld_data;
  logic [4:0] k_len;
  logic ld_ready, mac_en, mac_upd, mac_clr, busy, run_done, start_err;
  logic [4*N-1:0] a_edge, b_edge;
  logic [6:0] ctl;

  int checks = 0;
  int errors = 0;
  int am[N][K_MAX];
  int bm[N][K_MAX];
  int acc[N][N];
  int ap[N][N];
  int bp[N][N];

  always #5 CLK = ~CLK;

  assign ctl = {busy, mac_clr, mac_en, mac_upd, run_done, ld_ready, start_err};

  mac_feeder #(.N(N), .K_MAX(K_MAX)) dut (
    .CLK(CLK), .RSTN(RSTN), .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_idx(ld_idx),
    .ld_k(ld_k), .ld_data(ld_data), .ld_ready(ld_ready), .start(start), .k_len(k_len),
    .stall(stall), .a_edge(a_edge), .b_edge(b_edge), .mac_en(mac_en), .mac_upd(mac_upd),
    .mac_clr(mac_clr), .busy(busy), .run_done(run_done), .start_err(start_err)
  );

  function automatic int s4(logic [3:0] v);
    return int'($signed(v));
  endfunction

  // Attached NxN array: operands shift east/south, PE accumulates when enable & update_ready.
  always @(posedge CLK) begin
    if (mac_en && mac_upd) begin
      if (mac_clr) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            acc[i][j] = 0; ap[i][j] = 0; bp[i][j] = 0;
          end
      end else begin
        int na[N][N];
        int nb[N][N];
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            na[i][j] = (j == 0) ? s4(a_edge[4*i +: 4]) : ap[i][j-1];
            nb[i][j] = (i == 0) ? s4(b_edge[4*j +: 4]) : bp[i-1][j];
            acc[i][j] += na[i][j] * nb[i][j];
          end
        ap = na;
        bp = nb;
      end
    end
  end

  function automatic logic [4*N-1:0] exp_edge(bit isb, int c, int k);
    logic [4*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = c - i;
      if (d >= 0 && d < k) v[4*i +: 4] = isb ? 4'(bm[i][d]) : 4'(am[i][d]);
    end
    return v;
  endfunction

  function automatic int dot(int i, int j, int k);
    int s;
    s = 0;
    for (int kk = 0; kk < k; kk++) s += am[i][kk] * bm[j][kk];
    return s;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        am[i][k] = 0; bm[i][k] = 0;
      end
  endtask

  task automatic load(bit sel, int idx, int k, int val);
    @(negedge CLK);
    ld_valid = 1'b1; ld_sel = sel; ld_idx = idx[1:0]; ld_k = k[3:0]; ld_data = val[3:0];
    if (sel) bm[idx][k] = val; else am[idx][k] = val;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        load(0, i, k, $urandom_range(0, 15) - 8);
        load(1, i, k, $urandom_range(0, 15) - 8);
      end
    @(negedge CLK) ld_valid = 1'b0;
  endtask

  task automatic do_run(int k, int st_at, int st_len, bit ld_with_start, bit noise, bit chk_pe);
    int seq_c[$];
    bit seq_en[$];
    int nst;
    int L;
    L = k + 2*N - 2;
    for (int c = 0; c < L; c++) begin
      seq_c.push_back(c); seq_en.push_back(1'b1);
`ifdef MAC_FEEDER_STALL_EN
      if (c == st_at)
        for (int h = 0; h < st_len; h++) begin
          seq_c.push_back(c); seq_en.push_back(1'b0);
        end
`endif
    end
    @(negedge CLK);
    start = 1'b1; k_len = k[4:0];
    if (ld_with_start) begin
      int wi, wk, wv;
      wi = $urandom_range(0, N-1); wk = $urandom_range(0, k-1); wv = $urandom_range(0, 15) - 8;
      ld_valid = 1'b1; ld_sel = 1'b0; ld_idx = wi[1:0]; ld_k = wk[3:0]; ld_data = wv[3:0];
      am[wi][wk] = wv;
    end
    @(negedge CLK);
    start = 1'b0; ld_valid = 1'b0;
    checks++;
    if (ctl !== 7'b1111000) begin errors++; $display("FAIL clear_ctl got %b want %b", ctl, 7'b1111000); end
    checks++;
    if ({a_edge, b_edge} !== '0) begin errors++; $display("FAIL clear_edges got %h want 0", {a_edge, b_edge}); end
    nst = 0;
    for (int p = 0; p < seq_c.size(); p++) begin
      logic [6:0] ec;
      logic [4*N-1:0] ea, eb;
      @(negedge CLK);
      ec = {1'b1, 1'b0, seq_en[p], seq_en[p], 3'b000};
      ea = exp_edge(0, seq_c[p], k);
      eb = exp_edge(1, seq_c[p], k);
      checks++;
      if (ctl !== ec) begin errors++; $display("FAIL run_ctl p=%0d c=%0d got %b want %b", p, seq_c[p], ctl, ec); end
      checks++;
      if (a_edge !== ea) begin errors++; $display("FAIL a_edge c=%0d got %h want %h", seq_c[p], a_edge, ea); end
      checks++;
      if (b_edge !== eb) begin errors++; $display("FAIL b_edge c=%0d got %h want %h", seq_c[p], b_edge, eb); end
      if (seq_c[p] == st_at && nst < st_len) begin stall = 1'b1; nst++; end
      else stall = 1'b0;
      if (noise) begin
        start = 1'($urandom); k_len = 5'($urandom_range(0, 31));
        ld_valid = 1'($urandom); ld_sel = 1'($urandom); ld_idx = 2'($urandom);
        ld_k = 4'($urandom); ld_data = 4'($urandom);
      end
    end
    @(negedge CLK);
    stall = 1'b0; start = 1'b0; ld_valid = 1'b0;
    checks++;
    if (ctl !== 7'b1000100) begin errors++; $display("FAIL done_ctl got %b want %b", ctl, 7'b1000100); end
    checks++;
    if ({a_edge, b_edge} !== '0) begin errors++; $display("FAIL done_edges got %h want 0", {a_edge, b_edge}); end
    @(negedge CLK);
    checks++;
    if (ctl !== 7'b0000010) begin errors++; $display("FAIL after_done_ctl got %b want %b", ctl, 7'b0000010); end
    if (chk_pe)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          checks++;
          if (acc[i][j] != dot(i, j, k)) begin
            errors++; $display("FAIL pe[%0d][%0d] got %0d want %0d", i, j, acc[i][j], dot(i, j, k));
          end
        end
  endtask

  task automatic test_reset();
    RSTN = 1'b0; ld_valid = 0; ld_sel = 0; ld_idx = 0; ld_k = 0; ld_data = 0;
    start = 0; k_len = 0; stall = 0;
    clear_model();
    repeat (3) @(negedge CLK);
    checks++;
    if (ctl !== 7'b0000010 || {a_edge, b_edge} !== '0) begin
      errors++; $display("FAIL reset_state got %b/%h want 0000010/0", ctl, {a_edge, b_edge});
    end
    RSTN = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(negedge CLK);
      start = 1'b1; k_len = (t == 0) ? 5'd0 : 5'd17;
      @(negedge CLK);
      start = 1'b0;
      checks++;
      if (ctl !== 7'b0000011) begin errors++; $display("FAIL start_err_pulse k=%0d got %b want 0000011", k_len, ctl); end
      @(negedge CLK);
      checks++;
      if (ctl !== 7'b0000010) begin errors++; $display("FAIL start_err_clear got %b want 0000010", ctl); end
    end
  endtask

  task automatic test_ones();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) begin
        load(0, i, k, 1); load(1, i, k, 2);
      end
    @(negedge CLK) ld_valid = 1'b0;
    do_run(3, -1, 0, 0, 0, 1);
    checks++;
    if (acc[N-1][N-1] != 6) begin errors++; $display("FAIL ones_corner got %0d want 6", acc[N-1][N-1]); end
  endtask

  task automatic test_skew();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) begin
        load(0, i, k, i + 1); load(1, i, k, k - i);
      end
    @(negedge CLK) ld_valid = 1'b0;
    do_run(4, -1, 0, 0, 0, 1);
  endtask

  task automatic test_max();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        load(0, i, k, -8); load(1, i, k, -8);
      end
    @(negedge CLK) ld_valid = 1'b0;
    do_run(16, -1, 0, 0, 0, 1);
    do_run(16, -1, 0, 0, 0, 1);
    checks++;
    if (acc[0][0] != 1024) begin errors++; $display("FAIL max_pe got %0d want 1024", acc[0][0]); end
  endtask

  task automatic test_stall();
    fill_rand();
    do_run(6, 2, 3, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int k, sa, sl;
      fill_rand();
      k = $urandom_range(1, K_MAX);
      sa = $urandom_range(0, k + 2*N - 3);
      sl = $urandom_range(1, 3);
      do_run(k, sa, sl, 1, 1, 1);
    end
  endtask

  task automatic test_reset_mid();
    fill_rand();
    @(negedge CLK);
    start = 1'b1; k_len = 5'd4;
    @(negedge CLK);
    start = 1'b0;
    repeat (6) @(negedge CLK);
    RSTN = 1'b0;
    clear_model();
    #1;
    checks++;
    if (ctl !== 7'b0000010 || {a_edge, b_edge} !== '0) begin
      errors++; $display("FAIL midrun_reset got %b/%h want 0000010/0", ctl, {a_edge, b_edge});
    end
    @(negedge CLK);
    RSTN = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(negedge CLK);
      checks++;
      if (ctl !== 7'b0000010) begin errors++; $display("FAIL post_reset_idle t=%0d got %b want 0000010", t, ctl); end
    end
    do_run(2, -1, 0, 0, 0, 1);
    fill_rand();
    do_run(5, -1, 0, 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_ones();
    test_skew();
    test_max();
    test_stall();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
